// File: rtl/serial_arith_pkg.sv
// Shared definitions for the byte-serial arithmetic units (subtractor now, adder later):
// FSM state encoding, default slice width and slice-counter sizing.
package serial_arith_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_e;

   localparam int BYTE_W_DEF = 8;

   // A single-slice configuration still needs a 1-bit counter to keep the ports legal.
   function automatic int slice_cnt_w(input int nslice);
      return (nslice > 1) ? $clog2(nslice) : 1;
   endfunction

endpackage

// File: rtl/sub_byte_slice.sv
// Combinational BYTE_W-bit subtract with borrow-in/borrow-out; one slice of the
// byte-serial subtractor datapath.
module sub_byte_slice #(
   parameter int BYTE_W = 8
) (
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              b_in,
   output logic [BYTE_W-1:0] d,
   output logic              b_out
);

   // The extra MSB of the widened difference wraps to 1 exactly when a < b + b_in.
   logic [BYTE_W:0] diff;

   assign diff  = {1'b0, a} - {1'b0, b} - {{BYTE_W{1'b0}}, b_in};
   assign d     = diff[BYTE_W-1:0];
   assign b_out = diff[BYTE_W];

endmodule

// File: rtl/serial_subtractor.sv
// Byte-serial WIDTH-bit subtractor (out = in1 - in2) with start/busy/done handshake.
// Define SERIAL_SUBTRACTOR_SIGNED_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int BYTE_W = BYTE_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             borrow
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int                NSLICE = WIDTH / BYTE_W;
   localparam int                CNT_W  = slice_cnt_w(NSLICE);
   localparam logic [CNT_W-1:0]  LAST   = CNT_W'(NSLICE - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               bin_q, bin_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic               borrow_q, borrow_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
   logic               ovf_q, ovf_d;
`endif

   logic [BYTE_W-1:0]  a_slice, b_slice, d_slice;
   logic               bout_slice;

   // Single shared slice datapath; the counter selects which byte of the latched operands it sees.
   assign a_slice = a_q[int'(cnt_q) * BYTE_W +: BYTE_W];
   assign b_slice = b_q[int'(cnt_q) * BYTE_W +: BYTE_W];

   sub_byte_slice #(
      .BYTE_W (BYTE_W)
   ) u_slice (
      .a     (a_slice),
      .b     (b_slice),
      .b_in  (bin_q),
      .d     (d_slice),
      .b_out (bout_slice)
   );

   always_comb begin
      // NOTE: every _d gets a default first, so no path through the case can infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      bin_d    = bin_q;
      out_d    = out_q;
      borrow_d = borrow_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = in1;
               b_d     = in2;
               bin_d   = 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            res_d[int'(cnt_q) * BYTE_W +: BYTE_W] = d_slice;
            bin_d = bout_slice;
            if (cnt_q == LAST) begin
               // res_d already carries the slice computed this cycle.
               out_d    = res_d;
               borrow_d = bout_slice;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               cnt_d    = '0;
               state_d  = IDLE;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
               ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; all _d values come from always_comb.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         bin_q    <= 1'b0;
         out_q    <= '0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         bin_q    <= bin_d;
         out_q    <= out_d;
         borrow_q <= borrow_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign out    = out_q;
   assign borrow = borrow_q;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
   assign ovf    = ovf_q;
`endif

endmodule
